uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (8 data bits + optional parity), LSB first.
// Latency: start accepted on edge t0 drives the start bit and busy from t0; busy falls at t0 + 10*CLKS_PER_BIT (11*CLKS_PER_BIT with parity).
// Backpressure: none; start is dropped while busy, the producer must wait for busy=0 (IDLE accepts on the first edge after busy falls).
//
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset; aborts any frame in flight, tx returns high
//   start    one-cycle send request, honoured only in IDLE
//   in_data  byte to send, captured on the accepting edge only
//   busy     registered, high while a frame is on the line
//   tx       registered serial output, idles high
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after data
// bit 7 (even parity when PARITY_ODD=0, odd when PARITY_ODD=1). Without the
// macro the frame is plain 8N1 and PARITY_ODD has no effect.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  // Reject configurations the bit timing cannot honour.
  if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx: CLKS_PER_BIT must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            baud_done;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  // Terminal count of the current bit period.
  always_comb begin
    baud_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  end

  // Each state holds tx for CLKS_PER_BIT cycles; on the terminal edge the next
  // bit value is registered onto tx directly so bit periods stay exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_reg  <= in_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^in_data) ^ PARITY_ODD[0];
`endif
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            // shift_reg[0] is the bit now on the line; [1] is the next one.
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at CLKS_PER_BIT=4.
// Stimulus pushes each byte it expects on the line; a line decoder pops and
// compares every frame it sees, and a busy monitor checks every frame length.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int N_FRAMES   = 15;
`else
  localparam int FRAME_BITS = 10;
  localparam int N_FRAMES   = 13;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in_data;
  logic       busy;
  logic       tx;

  int         checks;
  int         failures;
  int         frames_seen;
  logic       last_par;
  logic [7:0] exp_q[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in_data(in_data),
    .busy   (busy),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n falling edges, remembering whether reset was seen meanwhile.
  task automatic step(input int n, inout bit aborted);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) aborted = 1'b1;
    end
  endtask

  // Line decoder: samples every bit mid-period and scores the frame.
  initial begin : decoder
    logic       prev_tx;
    logic [7:0] got;
    logic [7:0] exp_byte;
    logic       sb;
    logic       eb;
    logic       pb;
    bit         ab;
    prev_tx = 1'b1;
    pb      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && prev_tx === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        step(CPB / 2, ab);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          step(CPB, ab);
          got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        step(CPB, ab);
        pb = tx;
`endif
        step(CPB, ab);
        eb = tx;
        if (!ab) begin
          frames_seen++;
          check("start_bit", 32'(sb), 32'd0);
          check("stop_bit", 32'(eb), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_frame: got byte 0x%0h expected no frame", got);
          end else begin
            exp_byte = exp_q.pop_front();
            check("frame_byte", 32'(got), 32'(exp_byte));
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 32'(pb), 32'((^exp_byte) ^ PODD[0]));
`endif
          end
          last_par = pb;
        end
      end
      prev_tx = tx;
    end
  end

  // Busy monitor: every completed frame must hold busy for the full frame.
  initial begin : busy_mon
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) cnt = 0;
      else if (busy === 1'b1) cnt++;
      else if (cnt != 0) begin
        check("busy_width", cnt, FRAME_BITS * CPB);
        cnt = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit push);
    @(negedge clk);
    start   = 1'b1;
    in_data = b;
    if (push) exp_q.push_back(b);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("tx_start_bit", 32'(tx), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b after %0d cycles expected 0", name, busy, n);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] rb;
    checks      = 0;
    failures    = 0;
    frames_seen = 0;
    last_par    = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    in_data     = 8'h00;

    // Reset held with start toggling: line must stay idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start   = ~start;
      in_data = 8'(i * 37);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single byte 0xA5: line reads 0 | 1,0,1,0,0,1,0,1 | 1.
    send(8'hA5, 1'b1);
    wait_idle("idle_after_a5");

    // Ten pseudo-random bytes, one at a time.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($random);
      send(rb, 1'b1);
      wait_idle("idle_after_random");
    end

    // start mid-frame with different data must be ignored.
    send(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    start   = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle("idle_after_3c");
    repeat (60) @(negedge clk);
    check("no_second_frame_busy", 32'(busy), 32'd0);

    // Reset during DATA aborts at once; the next byte still goes out cleanly.
    send(8'hC3, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_abort_idle_tx", 32'(tx), 32'd1);
    send(8'h55, 1'b1);
    wait_idle("idle_after_55");

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones -> 1, 0x03 has two ones -> 0.
    send(8'h07, 1'b1);
    wait_idle("idle_after_07");
    check("parity_07", 32'(last_par), 32'd1);
    send(8'h03, 1'b1);
    wait_idle("idle_after_03");
    check("parity_03", 32'(last_par), 32'd0);
`endif

    repeat (20) @(negedge clk);
    check("frames_seen", frames_seen, N_FRAMES);
    check("pending_expected", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
